// File: rtl/tap_sequencer.sv
// tap_sequencer -- steps a coefficient table into a serial MAC, one tap per
// cycle, then waits for the MAC result and captures it.
//
// Frame: IDLE --sample_valid_i--> CLEAR (mac_rst_o) --> RUN (NTAPS cycles,
// clk_en_o, tapnum_o 0..NTAPS-1, tap_o = coef[tapnum_o]) --> WAIT until
// done_i (capture result_i into filt_o, filt_valid_o next cycle) or until
// 32 WAIT cycles pass (timeout_o pulse, filt_o kept).
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   sample_valid_i           start a frame (overrun_o pulse if busy)
//   coef_we_i/addr_i/data_i  coefficient write port (IDLE only)
//   tap_o, tapnum_o          coefficient and its index for the MAC
//   clk_en_o, mac_rst_o      MAC clock enable / MAC clear
//   result_i, done_i         MAC result and completion flag
//   filt_o, filt_valid_o     captured result and its strobe
//   busy_o                   any state other than IDLE
//   overrun_o, timeout_o     dropped-sample / missing-done pulses
//
// Build option: define TAPSEQ_COEF_LOAD_EN to make the coefficient table
// writable. Without it every coefficient is fixed at 1 (boxcar) and the
// coef_* inputs are ignored.
module tap_sequencer #(
  parameter int NTAPS  = 10,
  parameter int COEF_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sample_valid_i,
  input  logic              coef_we_i,
  input  logic [3:0]        coef_addr_i,
  input  logic [COEF_W-1:0] coef_data_i,
  output logic [COEF_W-1:0] tap_o,
  output logic [7:0]        tapnum_o,
  output logic              clk_en_o,
  output logic              mac_rst_o,
  input  logic [32:0]       result_i,
  input  logic              done_i,
  output logic [32:0]       filt_o,
  output logic              filt_valid_o,
  output logic              busy_o,
  output logic              overrun_o,
  output logic              timeout_o
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, WAIT} state_t;

  state_t            state_q, state_d;
  logic [7:0]        tapnum_q;
  logic [4:0]        tmo_q;
  logic [COEF_W-1:0] coef [NTAPS];
  logic              last_tap;
  logic              capture;
  logic              expire;

  assign last_tap = (tapnum_q == 8'(NTAPS - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE:  if (sample_valid_i) state_d = CLEAR;
      CLEAR: state_d = RUN;
      RUN:   if (last_tap) state_d = WAIT;
      WAIT: begin
        // done_i on the last allowed WAIT cycle still wins over the timeout
        if (done_i) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (tmo_q == 5'd31) begin
          expire  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tapnum_q     <= '0;
      tmo_q        <= '0;
      filt_o       <= '0;
      filt_valid_o <= 1'b0;
      overrun_o    <= 1'b0;
      timeout_o    <= 1'b0;
    end else begin
      // tap index only advances in RUN and is parked at 0 everywhere else
      tapnum_q     <= (state_q == RUN && !last_tap) ? tapnum_q + 8'd1 : 8'd0;
      // counter sits at 0 outside WAIT, so it is cleared on WAIT entry
      tmo_q        <= (state_q == WAIT) ? tmo_q + 5'd1 : 5'd0;
      filt_valid_o <= capture;
      timeout_o    <= expire;
      // busy includes the WAIT cycle that returns to IDLE
      overrun_o    <= sample_valid_i && (state_q != IDLE);
      if (capture) filt_o <= result_i;
    end
  end

`ifdef TAPSEQ_COEF_LOAD_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NTAPS; i++) coef[i] <= COEF_W'(1);
    end else if (coef_we_i && state_q == IDLE) begin
      // addresses >= NTAPS match no entry and are dropped
      for (int i = 0; i < NTAPS; i++)
        if (coef_addr_i == 4'(i)) coef[i] <= coef_data_i;
    end
  end
`else
  assign coef = '{default: COEF_W'(1)};

  logic unused_coef_port;
  assign unused_coef_port = ^{coef_we_i, coef_addr_i, coef_data_i};
`endif

  always_comb begin
    tap_o = coef[0];
    for (int i = 1; i < NTAPS; i++)
      if (tapnum_q == 8'(i)) tap_o = coef[i];
  end

  assign tapnum_o  = tapnum_q;
  assign busy_o    = (state_q != IDLE);
  assign mac_rst_o = (state_q == CLEAR);
  assign clk_en_o  = (state_q == RUN);

endmodule

// File: doc/tap_sequencer.md
TAP_SEQUENCER -- requirements
Module: tap_sequencer

Interface
REQ-001 SHALL have parameters NTAPS (default 10, number of filter taps, 1..16) and COEF_W (default 16, coefficient width).
REQ-002 SHALL have port clk_i, input, 1, single clock; all logic updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-004 SHALL have port sample_valid_i, input, 1, one-cycle strobe: a new signal window is loaded in the downstream MAC.
REQ-005 SHALL have ports coef_we_i (input, 1), coef_addr_i (input, 4) and coef_data_i (input, COEF_W), which form the coefficient write port.
REQ-006 SHALL have ports tap_o (output, COEF_W), tapnum_o (output, 8), clk_en_o (output, 1) and mac_rst_o (output, 1), which drive the MAC's tap, tapnum, clk_en_i and rst_i.
REQ-007 SHALL have ports result_i (input, 33) and done_i (input, 1), which are the MAC's result_o and done.
REQ-008 SHALL have ports filt_o (output, 33) and filt_valid_o (output, 1), the captured filter output and its one-cycle valid strobe.
REQ-009 SHALL have ports busy_o (output, 1, high in any state other than IDLE), overrun_o (output, 1, one-cycle pulse per dropped sample) and timeout_o (output, 1, one-cycle pulse).

Function
REQ-010 SHALL implement the FSM states IDLE, CLEAR, RUN and WAIT, holding an internal coefficient table coef[0..NTAPS-1].
REQ-011 SHALL go from IDLE to CLEAR on sample_valid_i, and otherwise hold IDLE.
REQ-012 SHALL assert mac_rst_o=1 for exactly the one cycle spent in CLEAR, then move to RUN.
REQ-013 SHALL, in RUN, step tapnum_o from 0 to NTAPS-1, one tap per cycle, with tap_o=coef[tapnum_o] and clk_en_o=1 in the same cycle.
REQ-014 SHALL move from RUN to WAIT after tapnum_o=NTAPS-1, with clk_en_o=0 in WAIT.
REQ-015 SHALL, in WAIT on done_i=1, register filt_o<=result_i, pulse filt_valid_o on the next cycle, and return to IDLE.
REQ-016 SHALL hold filt_o until the next capture.
REQ-017 SHALL run a 5-bit timeout counter that clears on entry to WAIT.
REQ-018 SHALL, if done_i has not arrived 32 cycles after entry to WAIT, pulse timeout_o, return to IDLE, not pulse filt_valid_o, and leave filt_o unchanged.
REQ-019 SHALL have a latency of NTAPS+2 cycles from the sample_valid_i edge to the first WAIT cycle (12 at default).
REQ-020 SHALL have a latency of 1 cycle from done_i to filt_valid_o.
REQ-021 SHALL, on sample_valid_i while busy_o=1, drop the sample, pulse overrun_o, and leave the current frame unaffected.
REQ-022 SHALL, on sample_valid_i in the same cycle that WAIT returns to IDLE, treat the sample as overrun.
REQ-023 SHALL ignore done_i outside WAIT.
REQ-024 SHALL hold tapnum_o=0 and tap_o=coef[0] outside RUN.

Reset
REQ-025 SHALL, with rst_i=1 at a clock edge, force state IDLE and set all outputs to 0: tapnum_o, clk_en_o, mac_rst_o, filt_o, filt_valid_o, busy_o, overrun_o and timeout_o.
REQ-026 SHALL, on that same reset edge, set tap_o to coef[0].
REQ-027 SHALL, on reset mid-frame, abandon the frame with no filt_valid_o, overrun_o or timeout_o pulse.
REQ-028 SHALL reset every coefficient to 16'h0001, giving a boxcar filter.

Configuration
REQ-029 SHALL have macro TAPSEQ_COEF_LOAD_EN, which compiles in the coefficient write port.
REQ-030 SHALL, when TAPSEQ_COEF_LOAD_EN is defined, accept a write coef[coef_addr_i]<=coef_data_i on coef_we_i=1 in IDLE only.
REQ-031 SHALL, when TAPSEQ_COEF_LOAD_EN is defined, ignore writes while busy_o=1 and writes with coef_addr_i>=NTAPS.
REQ-032 SHALL, when TAPSEQ_COEF_LOAD_EN is defined, make a write in cycle n visible on tap_o from cycle n+1.
REQ-033 SHALL, when TAPSEQ_COEF_LOAD_EN is not defined, keep the coefficient table constant at the reset values and ignore the coef_* inputs.

Verification
REQ-034 SHALL cover reset then sample_valid_i at cycle 0 -> mac_rst_o=1 at cycle 1; tapnum_o=0..9 with tap_o=0x0001 and clk_en_o=1 over cycles 2..11; WAIT at cycle 12.
REQ-035 SHALL cover done_i=1 with result_i=33'h0000000E at WAIT cycle 3 -> filt_o=0x0000000E with a one-cycle filt_valid_o at the next cycle, then busy_o=0.
REQ-036 SHALL cover, with the macro defined, writes coef[2]=0x0002 and coef[9]=0x0009 in IDLE -> tap_o=0x0002 at tapnum_o=2 and 0x0009 at tapnum_o=9 in the next frame.
REQ-037 SHALL cover a write of coef[3]=0x7FFF attempted during RUN -> tap_o=0x0001 at tapnum_o=3 in the next frame.
REQ-038 SHALL cover sample_valid_i at RUN cycle 5 -> overrun_o pulse, current frame completes normally, and no second frame starts.
REQ-039 SHALL cover done_i held low -> timeout_o pulses 32 cycles after WAIT entry, with no filt_valid_o.
REQ-040 SHALL cover rst_i=1 at RUN tapnum_o=4 -> all outputs 0 next cycle, and a new sample_valid_i restarts the sequence from CLEAR.
